// File: rtl/nn_result_writer_if.sv
// Write-back handshake bundle between NN_top, nn_result_writer and BRAM_IF.
// master = result writer, slave = the producer/BRAM side driving it.
interface nn_result_writer_if #(
    parameter int unsigned DATA_BIT_NUM    = 32,
    parameter int unsigned OUTPUT_NODE_NUM = 10
);
    logic                                    nn_final_output_valid;
    logic [DATA_BIT_NUM*OUTPUT_NODE_NUM-1:0] nn_final_output_reg;
    logic [31:0]                             nn_wr_addr_start;
    logic                                    nn_start_write;
    logic [31:0]                             nn_bram_addr;
    logic [DATA_BIT_NUM-1:0]                 nn_bram_write_data;
    logic                                    bram_complete;
    logic                                    wb_busy;
    logic                                    wb_done;
    logic                                    wb_overrun;

    modport master (
        input  nn_final_output_valid, nn_final_output_reg, nn_wr_addr_start, bram_complete,
        output nn_start_write, nn_bram_addr, nn_bram_write_data, wb_busy, wb_done, wb_overrun
    );

    modport slave (
        output nn_final_output_valid, nn_final_output_reg, nn_wr_addr_start, bram_complete,
        input  nn_start_write, nn_bram_addr, nn_bram_write_data, wb_busy, wb_done, wb_overrun
    );
endinterface

// File: rtl/nn_result_writer.sv
// Captures an NN result vector on a valid strobe and writes its words to BRAM one at a time
// through the BRAM_IF request/complete handshake, ascending address order.
module nn_result_writer #(
    parameter int unsigned DATA_BIT_NUM    = 32,
    parameter int unsigned OUTPUT_NODE_NUM = 10,
    parameter int unsigned ADDR_STRIDE     = 4
) (
    input logic             nn_clk,
    input logic             nn_rst_n,
    nn_result_writer_if.master wb
);
    localparam int unsigned IDX_W = (OUTPUT_NODE_NUM > 1) ? $clog2(OUTPUT_NODE_NUM) : 1;
    localparam int unsigned VEC_W = DATA_BIT_NUM * OUTPUT_NODE_NUM;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUT_NODE_NUM - 1);

    typedef enum logic [1:0] {StIdle, StReq, StGap, StDone} state_e;

    state_e                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [VEC_W-1:0]        vec_q;
    logic [31:0]             addr_q;
    logic [DATA_BIT_NUM-1:0] data_q;
    logic                    start_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    overrun_q;

    logic [IDX_W-1:0]        idx_nxt;
    logic [DATA_BIT_NUM-1:0] next_word;

    // Only consumed when idx_q != LAST_IDX, so the select stays in range whenever it matters.
    always_comb begin
        idx_nxt   = idx_q + 1'b1;
        next_word = vec_q[DATA_BIT_NUM*idx_nxt +: DATA_BIT_NUM];
    end

    always_ff @(posedge nn_clk or negedge nn_rst_n) begin
        if (!nn_rst_n) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            vec_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (wb.nn_final_output_valid && (state_q != StIdle)) begin
                overrun_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (wb.nn_final_output_valid) begin
                        vec_q   <= wb.nn_final_output_reg;
                        addr_q  <= wb.nn_wr_addr_start;
                        data_q  <= wb.nn_final_output_reg[DATA_BIT_NUM-1:0];
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        start_q <= 1'b1;
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    if (wb.bram_complete) begin
                        start_q <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            // Running address wraps modulo 2^32 like base + index*stride.
                            idx_q   <= idx_nxt;
                            addr_q  <= addr_q + 32'(ADDR_STRIDE);
                            data_q  <= next_word;
                            state_q <= StGap;
                        end
                    end
                end
                StGap: begin
                    start_q <= 1'b1;
                    state_q <= StReq;
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wb.nn_start_write     = start_q;
    assign wb.nn_bram_addr       = addr_q;
    assign wb.nn_bram_write_data = data_q;
    assign wb.wb_busy            = busy_q;
    assign wb.wb_done            = done_q;
    assign wb.wb_overrun         = overrun_q;
endmodule

// File: tb/tb_nn_result_writer.sv
// Bench for nn_result_writer: table of frames checked through a write scoreboard, plus
// hand sequences for reset abort, overrun, spurious completes and a single-word frame.
module tb_nn_result_writer;
    localparam int unsigned DW = 32;
    localparam int unsigned N  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nn_result_writer_if #(.DATA_BIT_NUM(DW), .OUTPUT_NODE_NUM(N)) bus ();
    nn_result_writer_if #(.DATA_BIT_NUM(DW), .OUTPUT_NODE_NUM(1)) bus1 ();

    nn_result_writer #(.DATA_BIT_NUM(DW), .OUTPUT_NODE_NUM(N), .ADDR_STRIDE(4)) dut (
        .nn_clk   (clk),
        .nn_rst_n (rst_n),
        .wb       (bus)
    );

    nn_result_writer #(.DATA_BIT_NUM(DW), .OUTPUT_NODE_NUM(1), .ADDR_STRIDE(4)) dut1 (
        .nn_clk   (clk),
        .nn_rst_n (rst_n),
        .wb       (bus1)
    );

    // BRAM_IF model: accept after delay_v cycles of held request; force_cpl injects completes.
    int   delay_v   = 0;
    int   hold_cnt  = 0;
    logic force_cpl = 1'b0;
    logic force1    = 1'b0;
    assign bus.bram_complete  = force_cpl | (bus.nn_start_write && (hold_cnt >= delay_v));
    assign bus1.bram_complete = force1 | bus1.nn_start_write;

    always @(posedge clk) begin
        if (!bus.nn_start_write || bus.bram_complete) hold_cnt <= 0;
        else hold_cnt <= hold_cnt + 1;
    end

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    int checks = 0;
    int passed = 0;
    int busy_cnt = 0, done_cnt = 0;
    int busy1_cnt = 0, done1_cnt = 0, w1_cnt = 0;
    logic [31:0] w1_addr = '0, w1_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wb_busy) busy_cnt++;
            if (bus.wb_done) done_cnt++;
            if (bus.nn_start_write) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                             bus.nn_bram_addr, bus.nn_bram_write_data);
                end else begin
                    check("wr_addr", bus.nn_bram_addr, exp_q[0].addr);
                    check("wr_data", bus.nn_bram_write_data, exp_q[0].data);
                    if (bus.bram_complete) void'(exp_q.pop_front());
                end
            end
            if (bus1.wb_busy) busy1_cnt++;
            if (bus1.wb_done) done1_cnt++;
            if (bus1.nn_start_write && bus1.bram_complete) begin
                w1_cnt++;
                w1_addr = bus1.nn_bram_addr;
                w1_data = bus1.nn_bram_write_data;
            end
        end
    end

    task automatic start_frame(input logic [31:0] base, input logic [127:0] vec);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            wr_t e;
            e.addr = base + 32'(i * 4);
            e.data = vec[i*32 +: 32];
            exp_q.push_back(e);
        end
        bus.nn_wr_addr_start      = base;
        bus.nn_final_output_reg   = vec;
        bus.nn_final_output_valid = 1'b1;
        busy_cnt = 0;
        done_cnt = 0;
        @(negedge clk);
        bus.nn_final_output_valid = 1'b0;
        // Scramble inputs after capture; the frame must not notice.
        bus.nn_final_output_reg   = {4{$urandom}};
        bus.nn_wr_addr_start      = $urandom;
    endtask

    task automatic wait_frame(input int exp_busy);
        for (int c = 0; c < 400 && done_cnt == 0; c++) @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("done_pulse_count", done_cnt, 1);
        check("busy_cycles", busy_cnt, exp_busy);
        check("busy_cleared", bus.wb_busy, 0);
        check("all_words_written", exp_q.size(), 0);
    endtask

    typedef struct {
        logic [31:0]  base;
        logic [127:0] vec;
        int           delay;
        logic         spurious;
        int           exp_busy;
    } vec_t;
    vec_t tbl[5];

    initial begin
        tbl[0] = '{32'h0000_0100, {32'h44, 32'h33, 32'h22, 32'h11}, 0, 1'b0, 8};
        tbl[1] = '{32'h0000_2000, {32'hA3A3_0004, 32'hA2A2_0003, 32'hA1A1_0002, 32'hA0A0_0001},
                   3, 1'b0, 20};
        tbl[2] = '{32'hFFFF_FFF8, {32'hDEAD_0004, 32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001},
                   0, 1'b0, 8};
        tbl[3] = '{32'h0000_0040, {32'h0BAD_F00D, 32'h1234_5678, 32'h8765_4321, 32'hFFFF_FFFF},
                   1, 1'b0, 12};
        // Complete held high: GAP and IDLE see it too, REQ accepts in one cycle.
        tbl[4] = '{32'h0000_0080, {32'h5555_5555, 32'hAAAA_AAAA, 32'h0000_0000, 32'h0F0F_0F0F},
                   2, 1'b1, 8};

        bus.nn_final_output_valid  = 1'b0;
        bus.nn_final_output_reg    = '0;
        bus.nn_wr_addr_start       = '0;
        bus1.nn_final_output_valid = 1'b0;
        bus1.nn_final_output_reg   = '0;
        bus1.nn_wr_addr_start      = '0;

        #12;
        check("rst_start_write", bus.nn_start_write, 0);
        check("rst_busy", bus.wb_busy, 0);
        check("rst_done", bus.wb_done, 0);
        check("rst_overrun", bus.wb_overrun, 0);
        check("rst_addr", bus.nn_bram_addr, 0);
        check("rst_data", bus.nn_bram_write_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a held request aborts the frame silently.
        delay_v = 10;
        start_frame(32'h0000_0300, {32'h4, 32'h3, 32'h2, 32'h1});
        repeat (3) @(negedge clk);
        check("midreq_start_write", bus.nn_start_write, 1);
        rst_n = 1'b0;
        #1;
        check("abort_start_write", bus.nn_start_write, 0);
        check("abort_busy", bus.wb_busy, 0);
        check("abort_done", bus.wb_done, 0);
        check("abort_addr", bus.nn_bram_addr, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        #1;
        check("abort_no_done", done_cnt, 0);
        check("abort_idle", bus.wb_busy, 0);

        for (int t = 0; t < 5; t++) begin
            delay_v   = tbl[t].delay;
            force_cpl = tbl[t].spurious;
            if (tbl[t].spurious) begin
                repeat (3) @(negedge clk);
                #1;
                check("idle_spurious_busy", bus.wb_busy, 0);
                check("idle_spurious_start", bus.nn_start_write, 0);
            end
            start_frame(tbl[t].base, tbl[t].vec);
            wait_frame(tbl[t].exp_busy);
            force_cpl = 1'b0;
        end
        check("no_overrun_yet", bus.wb_overrun, 0);

        // Second strobe while word 2 is in flight.
        delay_v = 1;
        start_frame(32'h0000_1000, {32'hC4, 32'hC3, 32'hC2, 32'hC1});
        for (int c = 0; c < 100 && exp_q.size() > 2; c++) @(posedge clk);
        @(negedge clk);
        bus.nn_final_output_reg   = {32'hEE, 32'hEE, 32'hEE, 32'hEE};
        bus.nn_wr_addr_start      = 32'h0000_9000;
        bus.nn_final_output_valid = 1'b1;
        @(negedge clk);
        bus.nn_final_output_valid = 1'b0;
        wait_frame(12);
        check("overrun_set", bus.wb_overrun, 1);
        delay_v = 0;
        start_frame(tbl[0].base, tbl[0].vec);
        wait_frame(8);
        check("overrun_sticky", bus.wb_overrun, 1);

        // Single-word instance: spurious completes in IDLE, then one write then DONE.
        force1 = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("n1_idle_busy", bus1.wb_busy, 0);
        check("n1_idle_start", bus1.nn_start_write, 0);
        force1 = 1'b0;
        @(negedge clk);
        busy1_cnt = 0;
        done1_cnt = 0;
        w1_cnt    = 0;
        bus1.nn_final_output_reg   = 32'hCAFE_F00D;
        bus1.nn_wr_addr_start      = 32'h0000_0500;
        bus1.nn_final_output_valid = 1'b1;
        @(negedge clk);
        bus1.nn_final_output_valid = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("n1_writes", w1_cnt, 1);
        check("n1_addr", w1_addr, 32'h0000_0500);
        check("n1_data", w1_data, 32'hCAFE_F00D);
        check("n1_done", done1_cnt, 1);
        check("n1_busy_cycles", busy1_cnt, 2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
